// File: rtl/frontend_lock_ctrl.sv
// frontend_lock_ctrl: qualifies per-field measurements into a lock state, raises mode IRQs
// and commits double-buffered frontend config at field boundaries.
module frontend_lock_ctrl #(
   parameter int STABLE_FRAMES = 3,
   parameter int LOST_FRAMES   = 2,
   parameter int VTOTAL_TOL    = 1,
   parameter int PCNT_TOL      = 16,
   parameter int TIMEOUT       = 2700000
) (
   input  logic        CLK_MEAS_i,
   input  logic        reset_n,
   input  logic        frame_stb_i,
   input  logic [10:0] vtotal_i,
   input  logic [19:0] pcnt_frame_i,
   input  logic        interlace_i,
   input  logic        cfg_wr_i,
   input  logic [31:0] hv_cfg_i,
   input  logic [31:0] hv_cfg2_i,
   input  logic [31:0] hv_cfg3_i,
   input  logic        irq_clr_i,
   output logic [31:0] hv_in_config_o,
   output logic [31:0] hv_in_config2_o,
   output logic [31:0] hv_in_config3_o,
   output logic        cfg_busy_o,
   output logic [1:0]  state_o,
   output logic        lock_o,
   output logic        mode_change_o,
   output logic        irq_o,
   output logic [10:0] vtotal_o,
   output logic [19:0] pcnt_frame_o,
   output logic        interlace_o
);
   localparam int SW = $clog2(STABLE_FRAMES + 2);
   localparam int LW = $clog2(LOST_FRAMES + 2);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic signed [11:0] VT_TOL = 12'(VTOTAL_TOL);
   localparam logic signed [20:0] PC_TOL = 21'(PCNT_TOL);
   typedef enum logic [1:0] {NOSYNC = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2, LOST = 2'd3} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [LW-1:0] miss_q, miss_d;
   logic [10:0] cand_vt_q, cand_vt_d, ref_vt_q, ref_vt_d;
   logic [19:0] cand_pc_q, cand_pc_d, ref_pc_q, ref_pc_d;
   logic cand_il_q, cand_il_d, ref_il_q, ref_il_d;
   logic mc_q, mc_d, irq_q, irq_d, irq_set, busy_q, busy_d;
   logic commit, wd_to, match, lock_now, drop, load;
   logic [WW-1:0] wd_q, wd_d;
   logic [2:0][31:0] sh_q, sh_d, cfg_q, cfg_d;
   logic signed [11:0] dv;
   logic signed [20:0] dp;
   // Reference is the candidate while acquiring, the latched lock values otherwise.
   assign dv = $signed({1'b0, vtotal_i}) - $signed({1'b0, state_q == ACQUIRE ? cand_vt_q : ref_vt_q});
   assign dp = $signed({1'b0, pcnt_frame_i}) - $signed({1'b0, state_q == ACQUIRE ? cand_pc_q : ref_pc_q});
   assign match = dv >= -VT_TOL && dv <= VT_TOL && dp >= -PC_TOL && dp <= PC_TOL &&
                  interlace_i == (state_q == ACQUIRE ? cand_il_q : ref_il_q);
   assign wd_to = state_q != NOSYNC && wd_q == WW'(TIMEOUT - 1);
   assign wd_d = frame_stb_i ? '0 : wd_q == WW'(TIMEOUT - 1) ? wd_q : wd_q + 1'b1;
   // A write in the same cycle as a strobe defers the commit to a later strobe.
   assign commit = busy_q && !cfg_wr_i && (frame_stb_i || state_q == NOSYNC);
   assign busy_d = cfg_wr_i || (busy_q && !commit);
   assign sh_d = cfg_wr_i ? {hv_cfg3_i, hv_cfg2_i, hv_cfg_i} : sh_q;
   assign cfg_d = commit ? sh_q : cfg_q;
   assign irq_d = irq_set || (irq_q && !irq_clr_i);
   always_ff @(posedge CLK_MEAS_i) begin
      if (!reset_n) begin
         state_q   <= NOSYNC;
         stab_q    <= '0;
         miss_q    <= '0;
         cand_vt_q <= '0;
         cand_pc_q <= '0;
         cand_il_q <= 1'b0;
         ref_vt_q  <= '0;
         ref_pc_q  <= '0;
         ref_il_q  <= 1'b0;
         mc_q      <= 1'b0;
         irq_q     <= 1'b0;
         busy_q    <= 1'b0;
         wd_q      <= '0;
         sh_q      <= '0;
         cfg_q     <= '0;
      end else begin
         state_q   <= state_d;
         stab_q    <= stab_d;
         miss_q    <= miss_d;
         cand_vt_q <= cand_vt_d;
         cand_pc_q <= cand_pc_d;
         cand_il_q <= cand_il_d;
         ref_vt_q  <= ref_vt_d;
         ref_pc_q  <= ref_pc_d;
         ref_il_q  <= ref_il_d;
         mc_q      <= mc_d;
         irq_q     <= irq_d;
         busy_q    <= busy_d;
         wd_q      <= wd_d;
         sh_q      <= sh_d;
         cfg_q     <= cfg_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      stab_d    = stab_q;
      miss_d    = miss_q;
      cand_vt_d = cand_vt_q;
      cand_pc_d = cand_pc_q;
      cand_il_d = cand_il_q;
      ref_vt_d  = ref_vt_q;
      ref_pc_d  = ref_pc_q;
      ref_il_d  = ref_il_q;
      mc_d      = 1'b0;
      irq_set   = 1'b0;
      lock_now  = 1'b0;
      drop      = 1'b0;
      load      = 1'b0;
      if (wd_to) begin
         state_d = NOSYNC;
         irq_set = state_q[1];
         stab_d  = '0;
         miss_d  = '0;
      end else if (frame_stb_i) begin
         case (state_q)
            NOSYNC: begin
               load     = 1'b1;
               state_d  = ACQUIRE;
               lock_now = STABLE_FRAMES == 1;
            end
            ACQUIRE: begin
               load     = !match;
               stab_d   = stab_q + 1'b1;
               lock_now = match && stab_q + 1'b1 >= SW'(STABLE_FRAMES);
            end
            LOCKED: begin
               miss_d  = match ? miss_q : LW'(1);
               state_d = match ? LOCKED : LOST;
               drop    = !match && LOST_FRAMES == 1;
            end
            LOST: begin
               miss_d  = match ? '0 : miss_q + 1'b1;
               state_d = match ? LOCKED : LOST;
               drop    = !match && miss_q + 1'b1 >= LW'(LOST_FRAMES);
            end
         endcase
         if (drop) begin
            state_d = ACQUIRE;
            load    = 1'b1;
            miss_d  = '0;
            irq_set = 1'b1;
         end
         if (load) begin
            cand_vt_d = vtotal_i;
            cand_pc_d = pcnt_frame_i;
            cand_il_d = interlace_i;
            stab_d    = SW'(1);
         end
         if (lock_now) begin
            state_d  = LOCKED;
            ref_vt_d = vtotal_i;
            ref_pc_d = pcnt_frame_i;
            ref_il_d = interlace_i;
            mc_d     = 1'b1;
            irq_set  = 1'b1;
         end
      end
   end
   always_comb begin
      state_o       = state_q;
      lock_o        = state_q[1];
      mode_change_o = mc_q;
      irq_o         = irq_q;
      cfg_busy_o    = busy_q;
      vtotal_o      = ref_vt_q;
      pcnt_frame_o  = ref_pc_q;
      interlace_o   = ref_il_q;
      {hv_in_config3_o, hv_in_config2_o, hv_in_config_o} = cfg_q;
   end
endmodule

// File: tb/tb_frontend_lock_ctrl.sv
// tb_frontend_lock_ctrl: table-driven vectors through a scoreboard queue for frontend_lock_ctrl.
module tb_frontend_lock_ctrl;
   localparam int TO = 40;
   localparam logic [31:0] C1 = 32'h3C0A035A, C2 = 32'h11223344, C3 = 32'hAAAA5555;
   localparam logic [31:0] C4 = 32'h5A5A0F0F, C5 = 32'hCAFEF00D;
   typedef struct {
      logic rn, s; logic [10:0] vt; logic [19:0] pc; logic il, w; logic [31:0] c; logic cl;
      logic [1:0] st; logic lk, mc, irq, bz; logic [10:0] evt; logic [19:0] epc; logic [31:0] ecfg;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, il = 1'b0, wr = 1'b0, clr = 1'b0;
   logic [10:0] vt = '0;
   logic [19:0] pc = '0;
   logic [31:0] cfg = '0, cfg2, cfg3, cfg_o, cfg2_o, cfg3_o;
   logic busy_o, lock_o, mc_o, irq_o, il_o;
   logic [1:0] st_o;
   logic [10:0] vt_o;
   logic [19:0] pc_o;
   int n_cmp = 0, n_bad = 0;
   vec_t tbl[$];
   vec_t sb[$];
   function automatic logic [31:0] rot(input logic [31:0] x);
      return {x[15:0], x[31:16]};
   endfunction
   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction
   assign cfg2 = rot(cfg);
   assign cfg3 = bswap(cfg);
   frontend_lock_ctrl #(.STABLE_FRAMES(3), .LOST_FRAMES(2), .VTOTAL_TOL(1), .PCNT_TOL(16), .TIMEOUT(TO)) dut (
      .CLK_MEAS_i(clk), .reset_n(rst_n), .frame_stb_i(stb), .vtotal_i(vt), .pcnt_frame_i(pc),
      .interlace_i(il), .cfg_wr_i(wr), .hv_cfg_i(cfg), .hv_cfg2_i(cfg2), .hv_cfg3_i(cfg3),
      .irq_clr_i(clr), .hv_in_config_o(cfg_o), .hv_in_config2_o(cfg2_o), .hv_in_config3_o(cfg3_o),
      .cfg_busy_o(busy_o), .state_o(st_o), .lock_o(lock_o), .mode_change_o(mc_o), .irq_o(irq_o),
      .vtotal_o(vt_o), .pcnt_frame_o(pc_o), .interlace_o(il_o));
   always #5 clk = ~clk;
   function automatic vec_t mk(input logic rn, s, input logic [10:0] v, input logic [19:0] p,
                               input logic i, w, input logic [31:0] c, input logic cl,
                               input logic [1:0] st, input logic lk, mc, irq, bz,
                               input logic [10:0] evt, input logic [19:0] epc, input logic [31:0] ecfg);
      vec_t r;
      r.rn = rn; r.s = s; r.vt = v; r.pc = p; r.il = i; r.w = w; r.c = c; r.cl = cl;
      r.st = st; r.lk = lk; r.mc = mc; r.irq = irq; r.bz = bz; r.evt = evt; r.epc = epc; r.ecfg = ecfg;
      return r;
   endfunction
   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask
   task automatic step(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rst_n = v.rn; stb = v.s; vt = v.vt; pc = v.pc; il = v.il; wr = v.w; cfg = v.c; clr = v.cl;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("state", idx, 32'(st_o), 32'(e.st));
      chk("lock", idx, 32'(lock_o), 32'(e.lk));
      chk("mode_change", idx, 32'(mc_o), 32'(e.mc));
      chk("irq", idx, 32'(irq_o), 32'(e.irq));
      chk("cfg_busy", idx, 32'(busy_o), 32'(e.bz));
      chk("vtotal_o", idx, 32'(vt_o), 32'(e.evt));
      chk("pcnt_frame_o", idx, 32'(pc_o), 32'(e.epc));
      chk("hv_in_config", idx, cfg_o, e.ecfg);
      chk("hv_in_config2", idx, cfg2_o, rot(e.ecfg));
      chk("hv_in_config3", idx, cfg3_o, bswap(e.ecfg));
   endtask
   initial begin
      tbl.push_back(mk(0,0,525,858000,0,0,0 ,0, 0,0,0,0,0,  0,     0, 0));
      tbl.push_back(mk(1,0,525,858000,0,0,0 ,0, 0,0,0,0,0,  0,     0, 0));
      tbl.push_back(mk(1,1,525,858000,0,0,0 ,0, 1,0,0,0,0,  0,     0, 0));
      tbl.push_back(mk(1,0,525,858000,0,0,0 ,0, 1,0,0,0,0,  0,     0, 0));
      tbl.push_back(mk(1,1,525,858000,0,0,0 ,0, 1,0,0,0,0,  0,     0, 0));
      tbl.push_back(mk(1,1,525,858010,0,0,0 ,0, 2,1,1,1,0,525,858010, 0));
      tbl.push_back(mk(1,0,525,858000,0,0,0 ,0, 2,1,0,1,0,525,858010, 0));
      tbl.push_back(mk(1,1,525,858000,0,0,0 ,0, 2,1,0,1,0,525,858010, 0));
      tbl.push_back(mk(1,0,525,858000,0,0,0 ,1, 2,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,526,858010,0,0,0 ,0, 2,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,527,858010,0,0,0 ,0, 3,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,525,858010,0,0,0 ,0, 2,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,525,858027,0,0,0 ,0, 3,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,525,857994,0,0,0 ,0, 2,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,525,858010,1,0,0 ,0, 3,1,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,1,625,864000,0,0,0 ,0, 1,0,0,1,0,525,858010, 0));
      tbl.push_back(mk(1,0,625,864000,0,0,0 ,1, 1,0,0,0,0,525,858010, 0));
      tbl.push_back(mk(1,0,625,864000,0,1,C1,0, 1,0,0,0,1,525,858010, 0));
      tbl.push_back(mk(1,0,625,864000,0,0,0 ,0, 1,0,0,0,1,525,858010, 0));
      tbl.push_back(mk(1,1,625,864000,0,0,0 ,0, 1,0,0,0,0,525,858010,C1));
      tbl.push_back(mk(1,1,625,864000,0,1,C2,0, 2,1,1,1,1,625,864000,C1));
      tbl.push_back(mk(1,0,625,864000,0,0,0 ,0, 2,1,0,1,1,625,864000,C1));
      tbl.push_back(mk(1,1,625,864000,0,0,0 ,0, 2,1,0,1,0,625,864000,C2));
      tbl.push_back(mk(1,0,625,864000,0,1,C3,0, 2,1,0,1,1,625,864000,C2));
      tbl.push_back(mk(1,1,625,864000,0,1,C4,0, 2,1,0,1,1,625,864000,C2));
      tbl.push_back(mk(1,1,625,864000,0,0,0 ,0, 2,1,0,1,0,625,864000,C4));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
      // Watchdog: last strobe was the previous edge; NOSYNC lands TO edges after it.
      step(mk(1,0,625,864000,0,0,0,1, 2,1,0,0,0,625,864000,C4), 100);
      for (int k = 2; k < TO; k++) step(mk(1,0,625,864000,0,0,0,0, 2,1,0,0,0,625,864000,C4), 100 + k);
      step(mk(1,0,625,864000,0,0,0,1, 0,0,0,1,0,625,864000,C4), 100 + TO);
      // NOSYNC commits on the cycle after the write.
      step(mk(1,0,625,864000,0,1,C5,0, 0,0,0,1,1,625,864000,C4), 200);
      step(mk(1,0,625,864000,0,0,0 ,0, 0,0,0,1,0,625,864000,C5), 201);
      // Relock, go LOST with a pending write, then a one-cycle reset.
      step(mk(1,1,525,858000,0,0,0 ,1, 1,0,0,0,0,625,864000,C5), 300);
      step(mk(1,1,525,858000,0,0,0 ,0, 1,0,0,0,0,625,864000,C5), 301);
      step(mk(1,1,525,858000,0,0,0 ,0, 2,1,1,1,0,525,858000,C5), 302);
      step(mk(1,1,600,858000,0,0,0 ,0, 3,1,0,1,0,525,858000,C5), 303);
      step(mk(1,0,600,858000,0,1,C1,0, 3,1,0,1,1,525,858000,C5), 304);
      step(mk(0,0,600,858000,0,0,0 ,0, 0,0,0,0,0,  0,     0, 0), 305);
      step(mk(1,0,600,858000,0,0,0 ,0, 0,0,0,0,0,  0,     0, 0), 306);
      @(negedge clk);
      stb = 1'b0; wr = 1'b0; clr = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
